// File: rtl/logs_map_engine.sv
// Logistic-map iterator x' = r*x*(1-x) in unsigned fixed point, built around one shared
// shift-add multiplier. Define LOGS_ORBIT_EN to stream every iterate instead of only the final one.
module logs_map_engine #(
  parameter int FRAC   = 4,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FRAC-1:0]   x0,
  input  logic [FRAC+1:0]   r,
  input  logic [ITER_W-1:0] n_iter,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC-1:0]   out_x,
  output logic              out_last,
  output logic              done
);

  localparam int AW = 2 * FRAC + 2;
  localparam int BW = $clog2(FRAC + 1);
  localparam logic [BW-1:0]     LAST_BIT = BW'(FRAC - 1);
  localparam logic [ITER_W-1:0] ONE      = ITER_W'(1);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, EMIT} state_t;

  state_t            state;
  logic [FRAC-1:0]   x;
  logic [FRAC+1:0]   r_q;
  logic [ITER_W-1:0] cnt;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     mcand;
  logic [FRAC-1:0]   mplier;
  logic [BW-1:0]     bit_cnt;
  logic              last_q;

  logic [AW-1:0]     acc_next;
  logic [FRAC-1:0]   prod_hi;
  logic              unused_bits;

  // The product's low FRAC bits and (for r*p) bits above 2*FRAC are truncated by the algorithm.
  assign acc_next    = acc + (mplier[0] ? mcand : '0);
  assign prod_hi     = acc_next[2*FRAC-1:FRAC];
  assign unused_bits = ^{acc_next[AW-1:2*FRAC], acc_next[FRAC-1:0]};

  assign busy = (state != IDLE);

  // NOTE: all state is updated with non-blocking assignments so every branch sees
  // the pre-edge values of acc/mcand/mplier regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      r_q       <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      bit_cnt   <= '0;
      last_q    <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x       <= x0;
            r_q     <= r;
            cnt     <= n_iter;
            mcand   <= AW'(x0);
            mplier  <= ~x0;
            acc     <= '0;
            bit_cnt <= '0;
            if (n_iter == '0) done  <= 1'b1;
            else              state <= MUL1;
          end
        end

        MUL1: begin
          acc     <= acc_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            mcand   <= AW'(r_q);
            mplier  <= prod_hi;
            acc     <= '0;
            bit_cnt <= '0;
            state   <= MUL2;
          end
        end

        MUL2: begin
          acc     <= acc_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            x       <= prod_hi;
            cnt     <= cnt - 1'b1;
            last_q  <= (cnt == ONE);
            acc     <= '0;
            bit_cnt <= '0;
`ifdef LOGS_ORBIT_EN
            state   <= EMIT;
`else
            if (cnt == ONE) begin
              state <= EMIT;
            end else begin
              // Intermediate iterate feeds straight back into the next multiply.
              mcand  <= AW'(prod_hi);
              mplier <= ~prod_hi;
              state  <= MUL1;
            end
`endif
          end
        end

        EMIT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_x     <= x;
            out_last  <= last_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              mcand  <= AW'(x);
              mplier <= ~x;
              state  <= MUL1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
